// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall control; optional stall counter under FWD_STALL_CNT_EN
module fwd_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic                id_uses_rn,
    input  logic                id_uses_rm,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                stall,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]         stall_count,
`endif
    output logic                ex_bubble
);
    localparam logic [REG_BITS-1:0] ZR = REG_BITS'(ZERO_REG);
    logic                ex_valid, ex_uses_rn, ex_uses_rm, ex_regwrite, ex_memread;
    logic [REG_BITS-1:0] ex_rn, ex_rm, ex_rd;
    logic                mem_valid, mem_regwrite, wb_valid, wb_regwrite;
    logic [REG_BITS-1:0] mem_rd, wb_rd;
    logic                mem_a, mem_b, wb_a, wb_b, ex_load, take;

    // Producer matches in MEM/WB for EX sources, and load-use detection against ID
    always_comb begin
        mem_a     = mem_valid && mem_regwrite && mem_rd == ex_rn && ex_rn != ZR;
        mem_b     = mem_valid && mem_regwrite && mem_rd == ex_rm && ex_rm != ZR;
        wb_a      = wb_valid && wb_regwrite && wb_rd == ex_rn && ex_rn != ZR;
        wb_b      = wb_valid && wb_regwrite && wb_rd == ex_rm && ex_rm != ZR;
        fwd_a_sel = !(ex_valid && ex_uses_rn) ? 2'b00 : mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
        fwd_b_sel = !(ex_valid && ex_uses_rm) ? 2'b00 : mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
        ex_load   = ex_valid && ex_memread && ex_regwrite && ex_rd != ZR;
        stall     = id_valid && !flush && ex_load &&
                    ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
        take      = id_valid && !flush && !stall;
        ex_bubble = !ex_valid;
    end

    // Pipeline shadow registers: shift EX->MEM->WB and load ID (or a bubble) unless frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {ex_valid, ex_uses_rn, ex_uses_rm, ex_regwrite, ex_memread} <= '0;
            {ex_rn, ex_rm, ex_rd} <= '0;
            {mem_valid, mem_regwrite, mem_rd} <= '0;
            {wb_valid, wb_regwrite, wb_rd} <= '0;
        end else if (!hold) begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            ex_valid     <= take;
            ex_regwrite  <= take && id_regwrite;
            ex_memread   <= take && id_memread;
            ex_uses_rn   <= id_uses_rn;
            ex_uses_rm   <= id_uses_rm;
            ex_rn        <= id_rn;
            ex_rm        <= id_rm;
            ex_rd        <= id_rd;
        end
    end

`ifdef FWD_STALL_CNT_EN
    // Saturating count of cycles that actually inserted a load-use bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && !hold && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench comparing the hazard unit against a stage-list reference model
module tb_fwd_hazard_unit;
    typedef struct packed {
        logic       v;
        logic [4:0] rn, rm;
        logic       urn, urm;
        logic [4:0] rd;
        logic       rw, mr;
    } st_t;
    typedef struct {
        logic [1:0]  a, b;
        logic        s, bub;
        logic [31:0] cnt;
    } exp_t;

    logic       clk = 0, reset = 0, hold = 0, flush = 0;
    logic       id_valid = 0, id_uses_rn = 0, id_uses_rm = 0, id_regwrite = 0, id_memread = 0;
    logic [4:0] id_rn = 0, id_rm = 0, id_rd = 0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, ex_bubble;
    logic [31:0] cnt_dut;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_count;
    assign cnt_dut = stall_count;
`else
    assign cnt_dut = 32'd0;
`endif

    fwd_hazard_unit dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
`ifdef FWD_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .ex_bubble(ex_bubble)
    );

    always #5 clk = ~clk;

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    st_t         pipe [3];
    exp_t        q[$];
    int unsigned cnt_m = 0;
    int          checks = 0, errors = 0;

    function automatic st_t mk(logic v, int rn, int rm, logic urn, logic urm, int rd, logic rw, logic mr);
        st_t s;
        s.v = v; s.rn = 5'(rn); s.rm = 5'(rm); s.urn = urn; s.urm = urm;
        s.rd = 5'(rd); s.rw = rw; s.mr = mr;
        return s;
    endfunction

    function automatic logic produces(st_t s, logic [4:0] r);
        return s.v && s.rw && s.rd == r && r != 5'd31;
    endfunction

    // Nearest older in-flight producer wins: MEM -> 10, WB -> 01
    function automatic logic [1:0] sel(logic u, logic [4:0] r);
        if (!pipe[0].v || !u) return 2'b00;
        for (int k = 1; k < 3; k++)
            if (produces(pipe[k], r)) return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic step(st_t i, logic f, logic h, logic r);
        exp_t e;
        logic s;
        @(posedge clk);
        #1;
        reset = r; hold = h; flush = f;
        id_valid = i.v; id_rn = i.rn; id_rm = i.rm; id_uses_rn = i.urn; id_uses_rm = i.urm;
        id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
        if (!r) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            cnt_m = 0;
        end
        s = i.v && !f && pipe[0].mr &&
            ((i.urn && produces(pipe[0], i.rn)) || (i.urm && produces(pipe[0], i.rm)));
        e.a = sel(pipe[0].urn, pipe[0].rn);
        e.b = sel(pipe[0].urm, pipe[0].rm);
        e.s = s;
        e.bub = !pipe[0].v;
`ifdef FWD_STALL_CNT_EN
        e.cnt = cnt_m;
`else
        e.cnt = 32'd0;
`endif
        q.push_back(e);
        if (r && !h) begin
            if (s && cnt_m != 32'hFFFF_FFFF) cnt_m++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (i.v && !f && !s) ? i : '0;
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
                chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
                chk("stall", 32'(stall), 32'(e.s));
                chk("ex_bubble", 32'(ex_bubble), 32'(e.bub));
                chk("stall_count", cnt_dut, e.cnt);
            end
        end
    end

    initial begin
        st_t nop, add1, ld9, use9;
        int  regs [5] = '{0, 1, 2, 3, 31};
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        add1 = mk(1, 2, 3, 1, 1, 1, 1, 0);
        ld9  = mk(1, 10, 0, 1, 0, 9, 1, 1);
        use9 = mk(1, 9, 9, 1, 1, 2, 1, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 1);
        // back-to-back EX/MEM forward
        step(add1, 0, 0, 1);
        step(mk(1, 1, 3, 1, 1, 2, 1, 0), 0, 0, 1);
        step(nop, 0, 0, 1);
        // MEM/WB forward on rm, then MEM priority
        step(add1, 0, 0, 1);
        step(mk(1, 7, 8, 1, 1, 6, 1, 0), 0, 0, 1);
        step(mk(1, 5, 1, 1, 1, 4, 1, 0), 0, 0, 1);
        step(add1, 0, 0, 1);
        step(add1, 0, 0, 1);
        step(mk(1, 5, 1, 1, 1, 4, 1, 0), 0, 0, 1);
        step(nop, 0, 0, 1);
        // load-use: one stall, bubble, then MEM/WB forward on both operands
        step(ld9, 0, 0, 1);
        step(use9, 0, 0, 1);
        step(use9, 0, 0, 1);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 1);
        // XZR is never forwarded nor stalled on
        step(mk(1, 2, 3, 1, 1, 31, 1, 0), 0, 0, 1);
        step(mk(1, 31, 31, 1, 1, 2, 1, 0), 0, 0, 1);
        step(mk(1, 10, 0, 1, 0, 31, 1, 1), 0, 0, 1);
        step(mk(1, 31, 31, 1, 1, 2, 1, 0), 0, 0, 1);
        step(nop, 0, 0, 1);
        // flush beats load-use
        step(ld9, 0, 0, 1);
        step(use9, 1, 0, 1);
        step(nop, 0, 0, 1);
        // hold keeps stall asserted and state frozen
        step(ld9, 0, 0, 1);
        step(use9, 0, 1, 1);
        step(use9, 0, 1, 1);
        step(use9, 0, 1, 1);
        step(use9, 0, 0, 1);
        step(use9, 0, 0, 1);
        step(nop, 0, 0, 1);
        // async reset with a producer in MEM and consumer in EX
        step(add1, 0, 0, 1);
        step(mk(1, 1, 1, 1, 1, 2, 1, 0), 0, 0, 1);
        step(nop, 0, 0, 0);
        step(add1, 0, 0, 1);
        step(nop, 0, 0, 1);
        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            st_t i;
            i = mk($urandom_range(0, 5) != 0, regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, regs[$urandom_range(0, 4)],
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step(i, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) != 0);
        end
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
